// File: rtl/fetch_stage_pkg.sv
// Shared widths, encodings and FSM states for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned PcWidth    = 8;
  localparam int unsigned InstrWidth = 8;

  // Encoding inserted into IF/ID as a bubble
  localparam logic [InstrWidth-1:0] Nop = 8'h00;

  typedef enum logic {
    StFetch = 1'b0,
    StHold  = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: bubble overrides load, otherwise contents are held.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [InstrWidth-1:0] load_instr,
  input  logic [PcWidth-1:0]    load_pc_plus1,
  output logic [InstrWidth-1:0] ifid_instr,
  output logic [PcWidth-1:0]    ifid_pc_plus1,
  output logic                  ifid_valid
);

  // Register update: bubble, load or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr    <= Nop;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (bubble) begin
      ifid_instr    <= Nop;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (load) begin
      ifid_instr    <= load_instr;
      ifid_pc_plus1 <= load_pc_plus1;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, one-entry stall buffer and FETCH/HOLD control feeding IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCWrite,
  input  logic                  IFIDWrite,
  input  logic                  branch_taken,
  input  logic [PcWidth-1:0]    branch_target,
  output logic                  imem_req,
  output logic [PcWidth-1:0]    imem_addr,
  input  logic                  imem_ready,
  input  logic [InstrWidth-1:0] imem_data,
  output logic [InstrWidth-1:0] ifid_instr,
  output logic [PcWidth-1:0]    ifid_pc_plus1,
  output logic                  ifid_valid
);

  state_e                state_q, state_d;
  logic [PcWidth-1:0]    pc_q, pc_d;
  logic [InstrWidth-1:0] buf_q, buf_d;
  // Low from reset until the first edge after release, so no request is
  // issued in the release cycle and a stale imem_ready there is ignored.
  logic                  live_q;

  logic                  advance;
  logic                  ready;
  logic [PcWidth-1:0]    pc_plus1;
  logic                  ifid_load;
  logic                  ifid_bubble;
  logic [InstrWidth-1:0] ifid_next_instr;

  assign advance   = PCWrite & IFIDWrite;
  assign pc_plus1  = pc_q + PcWidth'(1);
  assign imem_req  = live_q && (state_q == StFetch);
  assign imem_addr = pc_q;
  // Data only counts when we actually had a request out
  assign ready     = imem_ready & imem_req;

  // State, PC, buffer and request-enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= '0;
      buf_q   <= Nop;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state and IF/ID control; a taken branch overrides everything
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_d           = buf_q;
    ifid_load       = 1'b0;
    ifid_bubble     = 1'b0;
    ifid_next_instr = imem_data;
    if (branch_taken) begin
      pc_d        = branch_target;
      buf_d       = Nop;
      ifid_bubble = 1'b1;
      state_d     = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ready) begin
            if (advance) begin
              ifid_load = 1'b1;
              pc_d      = pc_plus1;
            end else begin
              buf_d   = imem_data;
              state_d = StHold;
            end
          end else if (IFIDWrite) begin
            ifid_bubble = 1'b1;
          end
        end
        StHold: begin
          if (advance) begin
            ifid_load       = 1'b1;
            ifid_next_instr = buf_q;
            pc_d            = pc_plus1;
            state_d         = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .load_instr    (ifid_next_instr),
    .load_pc_plus1 (pc_plus1),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid)
  );

endmodule
